// File: rtl/fx2_pipe.sv
// fx2_pipe: pipelined word/halfword rotate, shift-left and rotate-and-mask
// unit. The op is computed combinationally in front of stage 1. Later stages
// only carry the result and destination tag towards the output.
//
// Handshake: an op transfers on a rising edge where in_valid && in_ready, and
// a result transfers where out_valid && out_ready. in_ready is combinational
// (advance = !out_valid || out_ready). The whole pipe moves as one on advance
// and holds completely otherwise, so a stalled result stays stable.
module fx2_pipe #(
    parameter int DATA_W  = 128,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic              imm_sel,
    input  logic [DATA_W-1:0] ra,
    input  logic [DATA_W-1:0] rb,
    input  logic [6:0]        imm7,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int NW = DATA_W / 32;
    localparam int NH = DATA_W / 16;

    // op[0] selects halfword elements; op[2:1] selects the operation kind.
    localparam logic [1:0] K_ROT   = 2'd0;
    localparam logic [1:0] K_SHL   = 2'd1;
    localparam logic [1:0] K_ROTM  = 2'd2;
    localparam logic [1:0] K_ROTMA = 2'd3;

    // One 32-bit element. Right shifts take n = (-c) mod 64, so a set bit 5
    // means the whole element is shifted out.
    function automatic logic [31:0] calc_word(input logic [31:0] x,
                                              input logic [6:0]  c,
                                              input logic [1:0]  kind);
        logic [63:0] dbl;
        logic [6:0]  neg;
        logic [31:0] r;
        dbl = {x, x} << c[4:0];
        neg = 7'd0 - c;
        r   = '0;
        case (kind)
            K_ROT:   r = dbl[63:32];
            K_SHL:   r = c[5] ? 32'd0 : (x << c[4:0]);
            K_ROTM:  r = neg[5] ? 32'd0 : (x >> neg[4:0]);
            K_ROTMA: r = neg[5] ? {32{x[31]}} : 32'($signed(x) >>> neg[4:0]);
            default: r = '0;
        endcase
        return r;
    endfunction

    // One 16-bit element. Right shifts take n = (-c) mod 32.
    function automatic logic [15:0] calc_half(input logic [15:0] x,
                                              input logic [6:0]  c,
                                              input logic [1:0]  kind);
        logic [31:0] dbl;
        logic [6:0]  neg;
        logic [15:0] r;
        dbl = {x, x} << c[3:0];
        neg = 7'd0 - c;
        r   = '0;
        case (kind)
            K_ROT:   r = dbl[31:16];
            K_SHL:   r = c[4] ? 16'd0 : (x << c[3:0]);
            K_ROTM:  r = neg[4] ? 16'd0 : (x >> neg[3:0]);
            K_ROTMA: r = neg[4] ? {16{x[15]}} : 16'($signed(x) >>> neg[3:0]);
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [DATA_W-1:0] s1_result;
    logic              advance;

    logic              stage_valid [LATENCY];
    logic [DATA_W-1:0] stage_data  [LATENCY];
    logic [TAG_W-1:0]  stage_tag   [LATENCY];

    // Only the low 7 bits of each rb element act as a count.
    logic unused_rb;
    assign unused_rb = ^rb;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = stage_valid[LATENCY-1];
    assign result    = stage_data[LATENCY-1];
    assign out_tag   = stage_tag[LATENCY-1];

    // Stage-1 datapath: every element uses the count in its own position, so
    // element order inside the vector does not matter here.
    always_comb begin
        s1_result = '0;
        if (op[0]) begin
            for (int j = 0; j < NH; j++) begin
                s1_result[16*j +: 16] = calc_half(ra[16*j +: 16],
                                                  imm_sel ? imm7 : rb[16*j +: 7],
                                                  op[2:1]);
            end
        end else begin
            for (int j = 0; j < NW; j++) begin
                s1_result[32*j +: 32] = calc_word(ra[32*j +: 32],
                                                  imm_sel ? imm7 : rb[32*j +: 7],
                                                  op[2:1]);
            end
        end
    end

    // Pipeline registers: shift together on advance; flush kills all valids;
    // reset clears everything so result/out_tag read zero afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_valid[i] <= 1'b0;
                stage_data[i]  <= '0;
                stage_tag[i]   <= '0;
            end
        end else begin
            if (advance) begin
                stage_valid[0] <= in_valid;
                stage_data[0]  <= s1_result;
                stage_tag[0]   <= in_tag;
                for (int i = 1; i < LATENCY; i++) begin
                    stage_valid[i] <= stage_valid[i-1];
                    stage_data[i]  <= stage_data[i-1];
                    stage_tag[i]   <= stage_tag[i-1];
                end
            end
            if (flush) begin
                for (int i = 0; i < LATENCY; i++) begin
                    stage_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fx2_pipe.sv
// Directed bench for fx2_pipe: 128-bit/latency-2 main instance plus a
// 64-bit/latency-1 instance for the parametric check.
module tb_fx2_pipe;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic         imm_sel;
    logic [127:0] ra;
    logic [127:0] rb;
    logic [6:0]   imm7;
    logic [6:0]   in_tag;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] result;
    logic [6:0]   out_tag;

    logic         in_valid_b;
    logic         in_ready_b;
    logic [2:0]   op_b;
    logic         imm_sel_b;
    logic [63:0]  ra_b;
    logic [63:0]  rb_b;
    logic [6:0]   imm7_b;
    logic [6:0]   in_tag_b;
    logic         flush_b;
    logic         out_valid_b;
    logic         out_ready_b;
    logic [63:0]  result_b;
    logic [6:0]   out_tag_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] exp_q[$];
    logic [6:0]   tag_q[$];

    fx2_pipe #(.DATA_W(128), .LATENCY(2), .TAG_W(7)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .imm_sel(imm_sel), .ra(ra), .rb(rb), .imm7(imm7),
        .in_tag(in_tag), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .out_tag(out_tag)
    );

    fx2_pipe #(.DATA_W(64), .LATENCY(1), .TAG_W(7)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .op(op_b), .imm_sel(imm_sel_b), .ra(ra_b), .rb(rb_b), .imm7(imm7_b),
        .in_tag(in_tag_b), .flush(flush_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .result(result_b), .out_tag(out_tag_b)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] o, input logic s, input logic [127:0] a,
                         input logic [127:0] b, input logic [6:0] im, input logic [6:0] t);
        op       = o;
        imm_sel  = s;
        ra       = a;
        rb       = b;
        imm7     = im;
        in_tag   = t;
        in_valid = 1'b1;
    endtask

    // Issue one op with out_ready high and check latency, data and tag.
    task automatic run_op(input string name, input logic [2:0] o, input logic s,
                          input logic [127:0] a, input logic [127:0] b,
                          input logic [6:0] im, input logic [6:0] t,
                          input logic [127:0] exp);
        @(negedge clk);
        drive(o, s, a, b, im, t);
        #1;
        check({name, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check({name, "_early_valid"}, out_valid, 0);
        @(negedge clk);
        check({name, "_out_valid"}, out_valid, 1);
        check({name, "_result"}, result, exp);
        check({name, "_tag"}, out_tag, {121'd0, t});
    endtask

    logic [31:0]  stream_exp [4];
    logic [127:0] prev_res;
    logic [6:0]   prev_tag;
    logic         prev_stall;
    int           issued;
    int           got_n;

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; imm_sel = 1'b0; ra = '0; rb = '0; imm7 = '0; in_tag = '0;
        in_valid_b = 1'b0; flush_b = 1'b0; out_ready_b = 1'b1;
        op_b = '0; imm_sel_b = 1'b0; ra_b = '0; rb_b = '0; imm7_b = '0; in_tag_b = '0;
        stream_exp[0] = 32'h00000003; stream_exp[1] = 32'h00000006;
        stream_exp[2] = 32'h0000000C; stream_exp[3] = 32'h00000018;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_out_tag", out_tag, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        // Single ops, hand-computed results
        run_op("rot_rb", 3'd0, 1'b0, {4{32'h80000001}}, {4{32'd1}}, 7'd0, 7'h15,
               {4{32'h00000003}});
        run_op("rot_mixed", 3'd0, 1'b0, {4{32'h12345678}},
               {32'd0, 32'd1, 32'd8, 32'd31}, 7'd0, 7'h21,
               {32'h12345678, 32'h2468ACF0, 32'h34567812, 32'h091A2B3C});
        run_op("shl_rb", 3'd2, 1'b0, {4{32'hFFFFFFFF}},
               {32'd32, 32'd4, 32'd0, 32'd33}, 7'd0, 7'h22,
               {32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 32'h00000000});
        run_op("shlh_16", 3'd3, 1'b1, {8{16'hFFFF}}, '0, 7'd16, 7'h01, '0);
        run_op("shlh_15", 3'd3, 1'b1, {8{16'hFFFF}}, '0, 7'd15, 7'h02, {8{16'h8000}});
        run_op("rotma_m1", 3'd6, 1'b1, {4{32'h80000000}}, '0, 7'h7F, 7'h03, {4{32'hC0000000}});
        run_op("rotma_m32", 3'd6, 1'b1, {4{32'h80000000}}, '0, 7'h60, 7'h04, {4{32'hFFFFFFFF}});
        run_op("rotm_m1", 3'd4, 1'b1, {4{32'h80000000}}, '0, 7'h7F, 7'h05, {4{32'h40000000}});
        run_op("rotm_m32", 3'd4, 1'b1, {4{32'h80000000}}, '0, 7'h60, 7'h06, '0);
        run_op("roth_rb", 3'd1, 1'b0, {8{16'h1234}}, {4{16'd4, 16'd20}}, 7'd0, 7'h07,
               {8{16'h2341}});
        run_op("rotmh_rb", 3'd5, 1'b0, {8{16'h8001}}, {4{16'h007C, 16'hFFF0}}, 7'd0, 7'h08,
               {4{16'h0800, 16'h0000}});
        run_op("rotmah_imm", 3'd7, 1'b1, {8{16'h8001}}, '0, 7'h7C, 7'h09, {8{16'hF800}});

        // Stream of 4 ops with out_ready low in cycles 3..5
        @(negedge clk);
        in_valid = 1'b0;
        issued = 0; got_n = 0; prev_stall = 1'b0; prev_res = '0; prev_tag = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if (prev_stall) begin
                check("hold_result", result, prev_res);
                check("hold_tag", out_tag, prev_tag);
            end
            out_ready = !(cyc >= 3 && cyc <= 5);
            if (issued < 4)
                drive(3'd0, 1'b1, {4{32'h80000001}}, '0, 7'(issued + 1), 7'(10 + issued));
            else
                in_valid = 1'b0;
            #1;
            if (cyc == 4) check("stall_in_ready", in_ready, 0);
            if (in_valid && in_ready) begin
                exp_q.push_back({4{stream_exp[issued]}});
                tag_q.push_back(7'(10 + issued));
                issued++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_extra", out_valid, 0);
                end else begin
                    check("stream_result", result, exp_q.pop_front());
                    check("stream_tag", out_tag, tag_q.pop_front());
                    got_n++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = result;
            prev_tag   = out_tag;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_count", got_n, 4);
        check("stream_q_empty", exp_q.size(), 0);

        // Flush with two ops in flight (output stalled) and a third presented
        @(negedge clk);
        out_ready = 1'b0;
        drive(3'd0, 1'b1, {4{32'h80000001}}, '0, 7'd1, 7'h30);
        @(negedge clk);
        drive(3'd0, 1'b1, {4{32'h80000001}}, '0, 7'd2, 7'h31);
        @(negedge clk);
        drive(3'd0, 1'b1, {4{32'h80000001}}, '0, 7'd3, 7'h32);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b1;
        check("flush_out_valid_0", out_valid, 0);
        drive(3'd0, 1'b1, {4{32'h80000001}}, '0, 7'd4, 7'h33);
        @(negedge clk);
        in_valid = 1'b0;
        check("flush_out_valid_1", out_valid, 0);
        @(negedge clk);
        check("post_flush_valid", out_valid, 1);
        check("post_flush_result", result, {4{32'h00000018}});
        check("post_flush_tag", out_tag, 7'h33);

        // Flush on an idle pipe: op presented with in_ready high is dropped
        @(negedge clk);
        drive(3'd0, 1'b1, {4{32'h80000001}}, '0, 7'd1, 7'h34);
        flush = 1'b1;
        #1;
        check("flush_idle_in_ready", in_ready, 1);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_drop_0", out_valid, 0);
        @(negedge clk);
        check("flush_drop_1", out_valid, 0);

        // Reset mid-stream while a result is stalled at the output
        out_ready = 1'b0;
        drive(3'd2, 1'b1, {4{32'h0000FFFF}}, '0, 7'd4, 7'h3A);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_result", result, {4{32'h000FFFF0}});
        reset = 1'b1;
        drive(3'd0, 1'b1, {4{32'h80000001}}, '0, 7'd1, 7'h3B);
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_out_tag", out_tag, 0);
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_still_idle", out_valid, 0);

        // Parametric instance: DATA_W=64, LATENCY=1
        @(negedge clk);
        op_b = 3'd0; imm_sel_b = 1'b0; ra_b = {2{32'h80000001}}; rb_b = {2{32'd1}};
        in_tag_b = 7'h2A; in_valid_b = 1'b1;
        #1;
        check("p64_in_ready", in_ready_b, 1);
        @(negedge clk);
        in_valid_b = 1'b0;
        check("p64_out_valid", out_valid_b, 1);
        check("p64_result", result_b, 64'h0000000300000003);
        check("p64_tag", out_tag_b, 7'h2A);
        @(negedge clk);
        check("p64_drained", out_valid_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
